// File: rtl/conv_engine_if.sv
// Control and memory-port bundle for conv_engine; the engine is the slave side.
// Memory ports are fixed 1-cycle-latency reads; there is no backpressure anywhere.
interface conv_engine_if #(
   parameter int N      = 35,
   parameter int AW_IN  = 13,
   parameter int AW_WT  = 10,
   parameter int AW_OUT = 11
);
   logic              go;
   logic              relu_en;
   logic              busy;
   logic              done;
   logic              in_rd;
   logic [AW_IN-1:0]  in_addr;
   logic [N-1:0]      in_data;
   logic              wt_rd;
   logic [AW_WT-1:0]  wt_addr;
   logic [N-1:0]      wt_data;
   logic              out_we;
   logic [AW_OUT-1:0] out_addr;
   logic [N-1:0]      out_data;

   modport master (
      output go, relu_en, in_data, wt_data,
      input  busy, done, in_rd, in_addr, wt_rd, wt_addr, out_we, out_addr, out_data
   );

   modport slave (
      input  go, relu_en, in_data, wt_data,
      output busy, done, in_rd, in_addr, wt_rd, wt_addr, out_we, out_addr, out_data
   );
endinterface

// File: rtl/conv_engine.sv
// Direct conv engine, one MAC tap per cycle: IN_CH*K*K+3 cycles per output element.
// No backpressure: operand reads return one cycle later, results leave as single-cycle writes.
module conv_engine #(
   parameter int N      = 35,
   parameter int Q      = 32,
   parameter int IN_CH  = 8,
   parameter int OUT_CH = 8,
   parameter int IN_H   = 32,
   parameter int IN_W   = 32,
   parameter int K      = 3,
   parameter int STRIDE = 2,
   parameter int PAD    = 1,
   parameter int FLIP   = 1
) (
   input logic         clk,
   input logic         rst_n,
   conv_engine_if.slave bus
);
   localparam int OH     = (IN_H + 2*PAD - K) / STRIDE + 1;
   localparam int OW     = (IN_W + 2*PAD - K) / STRIDE + 1;
   localparam int ACC_W  = N + 8;
   localparam int AW_IN  = (IN_CH*IN_H*IN_W > 1) ? $clog2(IN_CH*IN_H*IN_W) : 1;
   localparam int AW_WT  = $clog2(OUT_CH*IN_CH*K*K + OUT_CH);
   localparam int AW_OUT = (OUT_CH*OH*OW > 1) ? $clog2(OUT_CH*OH*OW) : 1;
   localparam int ICW    = $clog2(IN_CH + 1);
   localparam int OCW    = $clog2(OUT_CH + 1);
   localparam int KW     = $clog2(K + 1);
   localparam int OYW    = $clog2(OH + 1);
   localparam int OXW    = $clog2(OW + 1);

   localparam logic [ICW-1:0] IC_LAST = ICW'(IN_CH - 1);
   localparam logic [OCW-1:0] OC_LAST = OCW'(OUT_CH - 1);
   localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);
   localparam logic [OYW-1:0] OY_LAST = OYW'(OH - 1);
   localparam logic [OXW-1:0] OX_LAST = OXW'(OW - 1);

   localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((64'sd1 <<< (N-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(64'sd1 <<< (N-1)));
   localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, WRITE, DONE} state_t;

   state_t              state, state_nx;
   logic [ICW-1:0]      ic, ic_nx;
   logic [KW-1:0]       kr, kr_nx, kc, kc_nx;
   logic [OCW-1:0]      oc, oc_nx;
   logic [OYW-1:0]      oy, oy_nx;
   logic [OXW-1:0]      ox, ox_nx;
   logic                relu_q;
   logic                bias_d, tap_d;
   logic signed [ACC_W-1:0] acc, acc_add, term, clip;
   logic signed [ACC_W:0]   sum;
   logic signed [2*N-1:0]   prod, prod_sh;
   int                  iy, ix, krw, kcw;
   logic                in_map;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ic     <= '0;
         kr     <= '0;
         kc     <= '0;
         oc     <= '0;
         oy     <= '0;
         ox     <= '0;
         relu_q <= 1'b0;
         bias_d <= 1'b0;
         tap_d  <= 1'b0;
         acc    <= '0;
      end else begin
         state  <= state_nx;
         ic     <= ic_nx;
         kr     <= kr_nx;
         kc     <= kc_nx;
         oc     <= oc_nx;
         oy     <= oy_nx;
         ox     <= ox_nx;
         if (state == IDLE && bus.go) relu_q <= bus.relu_en;
         bias_d <= (state == BIAS);
         tap_d  <= bus.in_rd;
         if (bias_d)     acc <= ACC_W'($signed(bus.wt_data));
         else if (tap_d) acc <= acc_add;
      end
   end

   always_comb begin
      state_nx = state;
      ic_nx    = ic;
      kr_nx    = kr;
      kc_nx    = kc;
      oc_nx    = oc;
      oy_nx    = oy;
      ox_nx    = ox;
      unique case (state)
         IDLE: if (bus.go) begin
            state_nx = BIAS;
            ic_nx = '0; kr_nx = '0; kc_nx = '0;
            oc_nx = '0; oy_nx = '0; ox_nx = '0;
         end
         BIAS: state_nx = MAC;
         MAC: begin
            // Tap order: kc fastest, then kr, then ic.
            if (kc != K_LAST) kc_nx = kc + 1'b1;
            else begin
               kc_nx = '0;
               if (kr != K_LAST) kr_nx = kr + 1'b1;
               else begin
                  kr_nx = '0;
                  if (ic != IC_LAST) ic_nx = ic + 1'b1;
                  else begin
                     ic_nx    = '0;
                     state_nx = DRAIN;
                  end
               end
            end
         end
         DRAIN: state_nx = WRITE;
         WRITE: begin
            state_nx = BIAS;
            if (ox != OX_LAST) ox_nx = ox + 1'b1;
            else begin
               ox_nx = '0;
               if (oy != OY_LAST) oy_nx = oy + 1'b1;
               else begin
                  oy_nx = '0;
                  if (oc != OC_LAST) oc_nx = oc + 1'b1;
                  else begin
                     oc_nx    = '0;
                     state_nx = DONE;
                  end
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      iy     = int'(oy) * STRIDE + int'(kr) - PAD;
      ix     = int'(ox) * STRIDE + int'(kc) - PAD;
      in_map = (iy >= 0) && (iy < IN_H) && (ix >= 0) && (ix < IN_W);
      krw    = (FLIP != 0) ? (K - 1 - int'(kr)) : int'(kr);
      kcw    = (FLIP != 0) ? (K - 1 - int'(kc)) : int'(kc);

      bus.in_rd   = (state == MAC) && in_map;
      bus.in_addr = bus.in_rd ? AW_IN'((int'(ic) * IN_H + iy) * IN_W + ix) : '0;
      bus.wt_rd   = (state == BIAS) || (state == MAC);
      bus.wt_addr = '0;
      if (state == BIAS)
         bus.wt_addr = AW_WT'(OUT_CH * IN_CH * K * K + int'(oc));
      else if (state == MAC)
         bus.wt_addr = AW_WT'(((int'(oc) * IN_CH + int'(ic)) * K + krw) * K + kcw);

      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   // Clamping the running sum keeps large partial sums from wrapping to the wrong sign.
   always_comb begin
      prod    = $signed(bus.in_data) * $signed(bus.wt_data);
      prod_sh = prod >>> Q;
      term    = ACC_W'(prod_sh);
      sum     = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
      if (sum[ACC_W] != sum[ACC_W-1]) acc_add = sum[ACC_W] ? AMIN : AMAX;
      else                            acc_add = sum[ACC_W-1:0];

      if (acc > OMAX)      clip = OMAX;
      else if (acc < OMIN) clip = OMIN;
      else                 clip = acc;
      if (relu_q && acc[ACC_W-1]) clip = '0;

      bus.out_we   = (state == WRITE);
      bus.out_addr = bus.out_we ? AW_OUT'((int'(oc) * OH + int'(oy)) * OW + int'(ox)) : '0;
      bus.out_data = bus.out_we ? N'(clip) : '0;
   end
endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: two configurations against an arithmetic reference model.
module tb_conv_engine;
   localparam int AWI0 = $clog2(16);
   localparam int AWW0 = $clog2(10);
   localparam int AWO0 = $clog2(4);
   localparam int AWI1 = $clog2(32);
   localparam int AWW1 = $clog2(38);
   localparam int AWO1 = $clog2(8);

   logic clk;
   logic rst_n;

   conv_engine_if #(.N(8), .AW_IN(AWI0), .AW_WT(AWW0), .AW_OUT(AWO0)) b0 ();
   conv_engine_if #(.N(8), .AW_IN(AWI1), .AW_WT(AWW1), .AW_OUT(AWO1)) b1 ();

   conv_engine #(.N(8), .Q(0), .IN_CH(1), .OUT_CH(1), .IN_H(4), .IN_W(4),
                 .K(3), .STRIDE(2), .PAD(1), .FLIP(1))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   conv_engine #(.N(8), .Q(4), .IN_CH(2), .OUT_CH(2), .IN_H(4), .IN_W(4),
                 .K(3), .STRIDE(2), .PAD(1), .FLIP(0))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic signed [7:0] in_m [2][32];
   logic signed [7:0] wt_m [2][38];
   int out_c [2][8];
   int wr_cnt [2];
   int done_cnt [2];
   int overlap;
   int n_chk, n_err;

   always @(posedge clk) begin
      if (b0.in_rd) b0.in_data <= in_m[0][b0.in_addr];
      if (b0.wt_rd) b0.wt_data <= wt_m[0][b0.wt_addr];
      if (b1.in_rd) b1.in_data <= in_m[1][b1.in_addr];
      if (b1.wt_rd) b1.wt_data <= wt_m[1][b1.wt_addr];
   end

   always @(negedge clk) begin
      if (b0.out_we) begin
         out_c[0][b0.out_addr] = int'($signed(b0.out_data));
         wr_cnt[0]++;
         if (b0.in_rd || b0.wt_rd) overlap++;
      end
      if (b1.out_we) begin
         out_c[1][b1.out_addr] = int'($signed(b1.out_data));
         wr_cnt[1]++;
         if (b1.in_rd || b1.wt_rd) overlap++;
      end
      if (b0.done) done_cnt[0]++;
      if (b1.done) done_cnt[1]++;
   end

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic get_done(input int d);
      return (d == 0) ? b0.done : b1.done;
   endfunction

   function automatic logic get_busy(input int d);
      return (d == 0) ? b0.busy : b1.busy;
   endfunction

   function automatic logic [4:0] get_ctl(input int d);
      if (d == 0) return {b0.busy, b0.done, b0.out_we, b0.in_rd, b0.wt_rd};
      return {b1.busy, b1.done, b1.out_we, b1.in_rd, b1.wt_rd};
   endfunction

   function automatic int get_odat(input int d);
      return (d == 0) ? int'(b0.out_data) : int'(b1.out_data);
   endfunction

   task automatic set_go(input int d, input logic g, input logic r);
      if (d == 0) begin b0.go = g; b0.relu_en = r; end
      else        begin b1.go = g; b1.relu_en = r; end
   endtask

   function automatic int exp_cycles(input int d);
      int ich;
      ich = (d == 0) ? 1 : 2;
      return ich * 4 * (ich * 9 + 3) + 1;
   endfunction

   // Plain convolution arithmetic over the 4x4, K=3, stride 2, pad 1 maps.
   function automatic longint ref_out(input int d, input int oc, input int oy, input int ox, input bit relu);
      int ich, q, iy, ix, wr, wc;
      bit flip;
      longint acc;
      ich  = (d == 0) ? 1 : 2;
      q    = (d == 0) ? 0 : 4;
      flip = (d == 0);
      acc  = longint'(wt_m[d][ich * ich * 9 + oc]);
      for (int ic = 0; ic < ich; ic++)
         for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
               iy = oy * 2 + kr - 1;
               ix = ox * 2 + kc - 1;
               if (iy >= 0 && iy < 4 && ix >= 0 && ix < 4) begin
                  wr  = flip ? 2 - kr : kr;
                  wc  = flip ? 2 - kc : kc;
                  acc += (longint'(in_m[d][(ic * 4 + iy) * 4 + ix]) *
                          longint'(wt_m[d][((oc * ich + ic) * 3 + wr) * 3 + wc])) >>> q;
               end
            end
      if (acc > 127)  acc = 127;
      if (acc < -128) acc = -128;
      if (relu && acc < 0) acc = 0;
      return acc;
   endfunction

   task automatic check_model(input int d, input bit relu, input string tag);
      int ne;
      ne = (d == 0) ? 4 : 8;
      for (int a = 0; a < ne; a++)
         check_val(tag, out_c[d][a], ref_out(d, a / 4, (a % 4) / 2, a % 2, relu));
   endtask

   task automatic run_job(input int d, input bit relu, input int go_at, input int rst_at, output int cyc);
      for (int a = 0; a < 8; a++) out_c[d][a] = -1000;
      wr_cnt[d]   = 0;
      done_cnt[d] = 0;
      @(negedge clk);
      set_go(d, 1'b1, relu);
      @(negedge clk);
      set_go(d, 1'b0, ~relu);
      cyc = 1;
      check_val("busy_after_go", get_busy(d), 1);
      while (get_done(d) == 1'b0 && cyc < 400) begin
         if (go_at != 0 && cyc == go_at)     set_go(d, 1'b1, relu);
         if (go_at != 0 && cyc == go_at + 1) set_go(d, 1'b0, ~relu);
         if (rst_at != 0 && cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_val("rst_ctl", get_ctl(d), 0);
            check_val("rst_odat", get_odat(d), 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic load_ones;
      for (int i = 0; i < 16; i++) in_m[0][i] = 8'sd1;
      for (int i = 0; i < 9; i++)  wt_m[0][i] = 8'sd1;
      wt_m[0][9] = 8'sd0;
   endtask

   int cyc;
   int e034 [4];
   int v;

   initial begin
      n_chk = 0; n_err = 0; overlap = 0;
      wr_cnt = '{0, 0}; done_cnt = '{0, 0};
      e034 = '{4, 6, 6, 9};
      rst_n = 1'b0;
      set_go(0, 1'b0, 1'b0);
      set_go(1, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) in_m[d][i] = '0;
         for (int i = 0; i < 38; i++) wt_m[d][i] = '0;
      end
      repeat (3) @(negedge clk);
      check_val("reset_ctl", get_ctl(0), 0);
      check_val("reset_in_addr", b0.in_addr, 0);
      check_val("reset_wt_addr", b0.wt_addr, 0);
      check_val("reset_out_addr", b0.out_addr, 0);
      check_val("reset_out_data", b0.out_data, 0);
      check_val("reset_ctl1", get_ctl(1), 0);
      rst_n = 1'b1;
      @(negedge clk);

      load_ones();
      run_job(0, 1'b0, 0, 0, cyc);
      check_val("ones_cycles", cyc, 49);
      check_val("ones_writes", wr_cnt[0], 4);
      check_val("ones_dones", done_cnt[0], 1);
      for (int a = 0; a < 4; a++) check_val("ones_out", out_c[0][a], e034[a]);
      check_model(0, 1'b0, "ones_model");

      run_job(0, 1'b0, 20, 0, cyc);
      check_val("rego_cycles", cyc, 49);
      check_val("rego_writes", wr_cnt[0], 4);
      check_val("rego_dones", done_cnt[0], 1);

      for (int i = 0; i < 16; i++) in_m[0][i] = 8'sd127;
      for (int i = 0; i < 9; i++)  wt_m[0][i] = 8'sd127;
      run_job(0, 1'b0, 0, 0, cyc);
      for (int a = 0; a < 4; a++) check_val("sat_pos", out_c[0][a], 127);
      for (int i = 0; i < 9; i++)  wt_m[0][i] = -8'sd127;
      run_job(0, 1'b0, 0, 0, cyc);
      for (int a = 0; a < 4; a++) check_val("sat_neg", out_c[0][a], -128);
      run_job(0, 1'b1, 0, 0, cyc);
      for (int a = 0; a < 4; a++) check_val("relu_neg", out_c[0][a], 0);

      load_ones();
      run_job(0, 1'b0, 0, 28, cyc);
      repeat (40) @(negedge clk);
      check_val("abort_writes", wr_cnt[0], 2);
      check_val("abort_dones", done_cnt[0], 0);
      run_job(0, 1'b0, 0, 0, cyc);
      check_val("restart_cycles", cyc, 49);
      check_val("restart_writes", wr_cnt[0], 4);
      for (int a = 0; a < 4; a++) check_val("restart_out", out_c[0][a], e034[a]);

      for (int i = 0; i < 16; i++) in_m[0][i] = '0;
      in_m[0][5] = 8'sd1;
      for (int i = 0; i < 9; i++) wt_m[0][i] = 8'(i + 1);
      wt_m[0][9] = '0;
      run_job(0, 1'b0, 0, 0, cyc);
      check_val("flip1_e00", out_c[0][0], 1);
      check_model(0, 1'b0, "flip1_model");

      for (int i = 0; i < 38; i++) wt_m[1][i] = '0;
      for (int i = 0; i < 9; i++)  wt_m[1][i] = 8'(i + 1);
      in_m[1][5] = 8'sh10;
      run_job(1, 1'b0, 0, 0, cyc);
      check_val("flip0_cycles", cyc, exp_cycles(1));
      check_val("flip0_e00", out_c[1][0], 9);
      check_model(1, 1'b0, "flip0_model");

      for (int i = 0; i < 38; i++) wt_m[1][i] = '0;
      in_m[1][5]  = 8'sh18;
      wt_m[1][8]  = 8'sh20;
      wt_m[1][36] = 8'sh10;
      run_job(1, 1'b0, 0, 0, cyc);
      check_val("fix_e00", out_c[1][0], 'h40);
      check_model(1, 1'b0, "fix_model");

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 32; i++) in_m[1][i] = 8'($urandom());
         for (int i = 0; i < 38; i++) wt_m[1][i] = 8'($urandom());
         v = int'($urandom_range(0, 1));
         run_job(1, v[0], 0, 0, cyc);
         check_val("rnd1_cycles", cyc, exp_cycles(1));
         check_val("rnd1_writes", wr_cnt[1], 8);
         check_val("rnd1_dones", done_cnt[1], 1);
         check_model(1, v[0], "rnd1_out");
      end

      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) begin
            v = int'($urandom_range(0, 30)) - 15;
            in_m[0][i] = 8'(v);
         end
         for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 30)) - 15;
            wt_m[0][i] = 8'(v);
         end
         v = int'($urandom_range(0, 1));
         run_job(0, v[0], 0, 0, cyc);
         check_val("rnd0_cycles", cyc, exp_cycles(0));
         check_model(0, v[0], "rnd0_out");
      end

      check_val("write_overlap", overlap, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter N, default 35, data word width (signed two's complement fixed point).
REQ-002 Parameter Q, default 32, fractional bits.
REQ-003 Parameter IN_CH, default 8, input channels.
REQ-004 Parameter OUT_CH, default 8, output channels.
REQ-005 Parameter IN_H, default 32, and IN_W, default 32: input feature-map height and width.
REQ-006 Parameter K, default 3, square kernel size; STRIDE, default 2; PAD, default 1, zero-pad border.
REQ-007 Parameter FLIP, default 1: 1 applies the kernel rotated 180 degrees (true convolution); 0 applies cross-correlation.
REQ-008 Derived: OH = (IN_H+2*PAD-K)/STRIDE+1; OW = (IN_W+2*PAD-K)/STRIDE+1; ACC_W = N+8; address widths are clog2 of region sizes.
REQ-009 clock  in  1  sole clock; all state changes on rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 go  in  1  start pulse; sampled only in IDLE.
REQ-012 relu_en  in  1  ReLU mode; captured when go is accepted.
REQ-013 busy  out  1  high from the cycle after go is accepted until done.
REQ-014 done  out  1  one-cycle pulse when the final output is written.
REQ-015 in_rd / in_addr / in_data  out / out / in  1 / AW_IN / N  input memory read; data valid exactly one cycle after in_rd.
REQ-016 wt_rd / wt_addr / wt_data  out / out / in  1 / AW_WT / N  weight+bias memory read; 1-cycle latency; bias for channel oc at address OUT_CH*IN_CH*K*K+oc.
REQ-017 out_we / out_addr / out_data  out / out / out  1 / AW_OUT / N  output write strobe, address, data.

Function
REQ-018 FSM states: IDLE, BIAS, MAC, DRAIN, WRITE, DONE.
REQ-019 IDLE->BIAS on go; BIAS issues the bias read for 1 cycle, then ->MAC.
REQ-020 MAC iterates ic (outer), kr, kc (inner); one tap per cycle; IN_CH*K*K cycles.
REQ-021 After the last tap, MAC->DRAIN (1 cycle, absorbs last data) ->WRITE (1 cycle, out_we=1).
REQ-022 WRITE advances ox, then oy, then oc and ->BIAS; after the last element, ->DONE (1 cycle, done=1) ->IDLE.
REQ-023 Cycles per output element = IN_CH*K*K+3; done is asserted OUT_CH*OH*OW*(IN_CH*K*K+3)+1 cycles after the go-accept edge.
REQ-024 Input tap coordinates: iy = oy*STRIDE+kr-PAD, ix = ox*STRIDE+kc-PAD; in_addr = (ic*IN_H+iy)*IN_W+ix.
REQ-025 Taps with iy or ix outside the map hold in_rd=0 and contribute exactly zero; the tap still consumes its cycle.
REQ-026 wt_addr = ((oc*IN_CH+ic)*K+kr')*K+kc', with kr'=K-1-kr, kc'=K-1-kc when FLIP=1, else kr'=kr, kc'=kc.
REQ-027 out_addr = (oc*OH+oy)*OW+ox.
REQ-028 Accumulator (ACC_W, signed) is loaded with the sign-extended bias, then adds each 2N-bit product arithmetic-shifted right by Q (truncation toward negative infinity).
REQ-029 out_data = accumulator saturated to [-2^(N-1), 2^(N-1)-1]; with relu_en set, negative results are written as 0.
REQ-030 go while busy is ignored; relu_en changes while busy have no effect.
REQ-031 out_we, in_rd and wt_rd are never high outside WRITE, MAC and BIAS/MAC respectively.

Reset
REQ-032 On reset low, FSM->IDLE immediately; busy, done, out_we, in_rd, wt_rd = 0; all address outputs, out_data, counters and accumulator = 0.
REQ-033 Reset mid-operation aborts without completing the in-flight write; the next go restarts from oc=oy=ox=0.

Verification
REQ-034 N=8, Q=0, IN_CH=OUT_CH=1, IN_H=IN_W=4, K=3, STRIDE=2, PAD=1; all inputs 1, weights 1, bias 0 -> writes addr0..3 = 4,6,6,9; done 49 cycles after go.
REQ-035 Same config, inputs 127, weights 127, bias 0 -> all outputs 127; weights -127 -> all -128; weights -127 with relu_en=1 -> all 0.
REQ-036 N=8, Q=4, single tap in the interior (input 0x18=1.5, weight 0x20=2.0, all other inputs 0, bias 0x10) -> the element covering that tap = 0x40 (4.0).
REQ-037 FLIP=1 vs FLIP=0 with weights 1..9 row-major and a single input of 1 at (1,1), all others 0 -> element (0,0): FLIP=1 gives 1, FLIP=0 gives 9.
REQ-038 Reset asserted for 1 cycle during the third element's MAC phase -> all outputs 0 and no further out_we; a second go yields the REQ-034 results and timing.
REQ-039 go pulsed again while busy -> ignored; exactly 4 writes and one done pulse.
